// File: rtl/sample_jitter_pipe_if.sv
// Bundle handshake interface for the sample-jitter stage.
// Sample word layout: lane l, axis a (0 = x, 1 = y) lives at bits [(2*l+a)*SIGFIG +: SIGFIG].
interface sample_jitter_pipe_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
);
  logic                          valid;
  logic                          ready;
  logic [SIGFIG*VERTS*AXIS-1:0]  tri_data;
  logic [SIGFIG*COLORS-1:0]      color_data;
  logic [SIGFIG*2*SAMPS-1:0]     sample_data;
  logic [SAMPS-1:0]              samp_valid;

  modport master (
    output valid, tri_data, color_data, sample_data, samp_valid,
    input  ready
  );

  modport slave (
    input  valid, tri_data, color_data, sample_data, samp_valid,
    output ready
  );
endinterface

// File: rtl/sample_jitter_pipe.sv
// Stallable sample-jitter stage: XOR-fold hash (optionally seeded) is OR'd into
// the fractional bits of every sample, then the bundle rides a PIPE_DEPTH-deep
// elastic valid/ready pipeline. Bundles with no valid lanes may be squashed.
module sample_jitter_pipe #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int SAMPS      = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int HASH_DROP  = 4,
  parameter int HASH_W     = RADIX - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  sample_jitter_pipe_if.slave     src,
  sample_jitter_pipe_if.master    dst,
  input  logic [3:0]              subSample,
  input  logic [1:0]              jit_mode,
  input  logic                    squash_en,
  input  logic                    seed_load,
  input  logic [2*HASH_W-1:0]     seed_in,
  output logic                    err_subsample
);

  localparam int TRI_W = SIGFIG * VERTS * AXIS;
  localparam int COL_W = SIGFIG * COLORS;
  localparam int SMP_W = SIGFIG * 2 * SAMPS;
  localparam int DW    = TRI_W + COL_W + SMP_W + SAMPS;
  localparam int HIN_W = 2 * (SIGFIG - HASH_DROP);
  localparam int NCH   = (HIN_W + HASH_W - 1) / HASH_W;
  localparam int PAD_W = NCH * HASH_W;
  localparam int JSH   = RADIX - HASH_W;
  localparam int LAST  = PIPE_DEPTH - 1;
  localparam logic [HASH_W-1:0] ONES = '1;

  logic [SMP_W-1:0]    jit_sample;
  logic [HASH_W-1:0]   mask;
  logic                sel_ok;
  logic [2*HASH_W-1:0] seed_q;
  logic [PIPE_DEPTH-1:0] stage_v;
  logic [PIPE_DEPTH-1:0] ready_at;
  logic [DW-1:0]       stage_data [PIPE_DEPTH];
  logic                accept;
  logic                push;

  // Zero-pad at the MSB to whole chunks, then XOR all chunks together.
  function automatic logic [HASH_W-1:0] fold(input logic [HIN_W-1:0] h);
    logic [PAD_W-1:0]  p;
    logic [HASH_W-1:0] acc;
    p   = PAD_W'(h);
    acc = '0;
    for (int c = 0; c < NCH; c++) acc ^= p[c*HASH_W +: HASH_W];
    return acc;
  endfunction

  // Own coordinate sits in the low field of the hash input, the other axis above it.
  function automatic logic [SIGFIG-1:0] jitter_axis(
    input logic [SIGFIG-1:0] own,
    input logic [SIGFIG-1:0] other,
    input logic [HASH_W-1:0] seed_axis,
    input logic [1:0]        mode,
    input logic [HASH_W-1:0] m
  );
    logic [HASH_W-1:0] f;
    logic [HASH_W-1:0] j;
    f = fold({other[SIGFIG-1:HASH_DROP], own[SIGFIG-1:HASH_DROP]});
    case (mode)
      2'd0:    j = '0;
      2'd1:    j = f;
      2'd2:    j = f ^ seed_axis;
      default: j = seed_axis;
    endcase
    return own | (SIGFIG'(j & m) << JSH);
  endfunction

  // MSAA select picks how many jitter bits survive; a bad select kills jitter.
  always_comb begin
    mask   = '0;
    sel_ok = 1'b1;
    case (subSample)
      4'b1000: mask = ONES;
      4'b0100: mask = ONES >> 1;
      4'b0010: mask = ONES >> 2;
      4'b0001: mask = ONES >> 3;
      default: sel_ok = 1'b0;
    endcase
  end

  // Jitter every lane at the input, regardless of lane valid.
  always_comb begin
    jit_sample = '0;
    for (int l = 0; l < SAMPS; l++) begin
      jit_sample[2*l*SIGFIG +: SIGFIG] = jitter_axis(
        src.sample_data[2*l*SIGFIG +: SIGFIG],
        src.sample_data[(2*l+1)*SIGFIG +: SIGFIG],
        seed_q[HASH_W-1:0], jit_mode, mask);
      jit_sample[(2*l+1)*SIGFIG +: SIGFIG] = jitter_axis(
        src.sample_data[(2*l+1)*SIGFIG +: SIGFIG],
        src.sample_data[2*l*SIGFIG +: SIGFIG],
        seed_q[2*HASH_W-1:HASH_W], jit_mode, mask);
    end
  end

  // Stall chain: a stage may load when it is empty or its content moves on.
  always_comb begin : ready_chain
    logic r;
    ready_at       = '0;
    r              = !stage_v[LAST] || dst.ready;
    ready_at[LAST] = r;
    for (int i = LAST - 1; i >= 0; i--) begin
      r           = !stage_v[i] || r;
      ready_at[i] = r;
    end
  end

  assign accept    = src.valid && ready_at[0];
  assign push      = accept && !(squash_en && (src.samp_valid == '0));
  assign src.ready = ready_at[0];

  assign dst.valid       = stage_v[LAST];
  assign dst.samp_valid  = stage_data[LAST][SAMPS-1:0];
  assign dst.sample_data = stage_data[LAST][SAMPS +: SMP_W];
  assign dst.color_data  = stage_data[LAST][SAMPS+SMP_W +: COL_W];
  assign dst.tri_data    = stage_data[LAST][SAMPS+SMP_W+COL_W +: TRI_W];

  // Seed register, sticky select error and the elastic pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q        <= '0;
      err_subsample <= 1'b0;
      stage_v       <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) stage_data[i] <= '0;
    end else begin
      if (seed_load) seed_q <= seed_in;
      if (accept && !sel_ok) err_subsample <= 1'b1;
      if (ready_at[0]) begin
        stage_v[0] <= push;
        if (push)
          stage_data[0] <= {src.tri_data, src.color_data, jit_sample, src.samp_valid};
      end
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        if (ready_at[i]) begin
          stage_v[i] <= stage_v[i-1];
          if (stage_v[i-1]) stage_data[i] <= stage_data[i-1];
        end
      end
    end
  end

endmodule

// File: doc/sample_jitter_pipe.md
# sample_jitter_pipe

Parametrised, stallable sample-jitter stage for the rasterizer back end, placed between the sample iterator and the sample test. It offsets each of SAMPS sample positions with an XOR-fold hash of the sample coordinates, optionally mixed with a per-frame seed. Triangle and colour data travel alongside in a PIPE_DEPTH-deep elastic pipeline with a valid/ready handshake on both sides. Bundles whose lanes are all invalid can be squashed before they enter the pipeline.

## Interface
- SIGFIG, 24, fixed-point word width
- RADIX, 10, fractional bits
- VERTS, 3, triangle vertices
- AXIS, 3, coordinates per vertex
- COLORS, 3, colour channels
- SAMPS, 4, sample lanes per bundle (≥1)
- PIPE_DEPTH, 2, register stages (≥1)
- HASH_DROP, 4, coordinate LSBs discarded before hashing
- HASH_W, RADIX-2, jitter width; jitter occupies bits [RADIX-1:RADIX-HASH_W]
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- in_valid  in  1  input bundle valid
- in_ready  out  1  stage can accept
- tri_in  in  SIGFIG×VERTS×AXIS  triangle, signed
- color_in  in  SIGFIG×COLORS  colour, unsigned
- sample_in  in  SIGFIG×2×SAMPS  sample x ([0]) and y ([1]), signed
- samp_valid_in  in  SAMPS  per-lane valid
- subSample  in  4  one-hot MSAA select, quasi-static
- jit_mode  in  2  0 = off, 1 = spatial hash, 2 = hash XOR seed, 3 = seed only
- squash_en  in  1  drop bundles with all lanes invalid
- seed_load  in  1  load seed register
- seed_in  in  2×HASH_W  {seed_y, seed_x}
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts
- tri_out, color_out, sample_out, samp_valid_out  out  same widths as the inputs  delayed bundle with jittered samples
- err_subsample  out  1  sticky flag: subSample was not one-hot

## Operation
- Accept: an input bundle is accepted when in_valid && in_ready. Tri, colour, lane valids, the current seed register, subSample and jit_mode are all captured into stage 0 with the bundle.
- Hash input for x: {sample_y[SIGFIG-1:HASH_DROP], sample_x[SIGFIG-1:HASH_DROP]}. For y the two fields swap places.
- Hash fold: zero-pad the hash input at the MSB to a multiple of HASH_W, then XOR all HASH_W chunks together.
- Mask: subSample[3] → all ones; [2] → mask>>1; [1] → mask>>2; [0] → mask>>3.
- Non-one-hot subSample: mask = 0 and err_subsample sets. The flag is cleared only by rst.
- Jitter value j per axis, before masking:
  - mode 0: 0
  - mode 1: fold
  - mode 2: fold ^ seed_axis
  - mode 3: seed_axis
- Jitter application: masked j is shifted left by RADIX-HASH_W, then OR'd into the sample. Nothing else in the sample changes.
- Jitter is computed combinationally at the input and registered in stage 0.
- Lane valids do not gate the hash. Invalid lanes still carry jittered coordinates.
- Squash: if squash_en and all samp_valid_in bits are 0, the bundle is consumed (in_ready as normal) but no stage-0 valid is created.
- Seed: seed_load writes seed_in at the clock edge. A bundle accepted in the same cycle captures the old seed. Bundles already in flight are unaffected.
- Pipeline: each stage holds a valid bit. A stage advances when the next stage is empty or itself advancing. The last stage advances on out_ready.
- in_ready = !v0 || stage0 advances. It is combinational from out_ready through the stall chain.
- Stall: while out_valid && !out_ready, all outputs hold stable. Nothing is lost or duplicated.

## Timing
- Reset: all stage valid bits 0, out_valid 0, all data outputs 0, seed 0, err_subsample 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards every in-flight bundle. Nothing emerges after reset deasserts.
- Latency: a bundle accepted at edge k has out_valid high after edge k+PIPE_DEPTH-1. This applies when there are no stalls.
- Throughput: one bundle per cycle with out_ready held high.
- Full: after PIPE_DEPTH bundles accumulate with out_ready low, in_ready drops. It rises in the same cycle that out_ready rises.
- Simultaneous pop and push on a full pipe is allowed and loses no cycle.

## Test plan
- Mode 1, x=0x000400, y=0, subSample=4'b1000 → after 2 cycles, sample_out x=0x000500, y=0x000010.
- Mode 3, seed_x=0xA5, x=0, subSample=4'b1000 → x=0x000294. Same with subSample=4'b0001 → x=0x000014.
- Mode 0, random bundles, out_ready toggled randomly → outputs equal inputs in order. No drops or duplicates. Stable while stalled.
- Back-to-back: 8 bundles, out_ready low for 5 cycles → in_ready low after 2 accepts. Resume releases all in order at 1 per cycle.
- squash_en=1, bundle with samp_valid_in=0 between two valid bundles → only the 2 valid bundles emerge. In mode 0 with squash_en=0 the empty bundle passes through unchanged.
- subSample=4'b0110 in mode 1 → jitter 0 and err_subsample=1 until rst. seed_load during acceptance → that bundle uses the old seed and the next one uses the new seed.
